// File: rtl/serial_sub_seq_pkg.sv
// ============================================================================
// Module      : serial_sub_seq_pkg
// Description : Shared state encoding and sizing helper for serial_sub_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Bit counter only has to reach WIDTH-1, so $clog2 suffices; floor at 1 bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : 1-bit full subtractor cell, d = a - b - ci, co = borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic d,
    output logic co
);

    assign d  = a ^ b ^ ci;
    assign co = (~a & b) | (~(a ^ b) & ci);

endmodule

`default_nettype wire

// File: rtl/serial_sub_seq.sv
// ============================================================================
// Module      : serial_sub_seq
// Description : Bit-serial WIDTH-bit subtractor sequencing one full_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub_seq
    import serial_sub_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_brw;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               w_d;
    logic               w_co;

    full_subtractor u_cell (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_brw),
        .d  (w_d),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= {w_d, r_res_sh[WIDTH-1:1]};
                    r_brw    <= w_co;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    // Last bit: publish the full result including this cycle's D.
                    if (r_cnt == c_last) begin
                        r_diff   <= {w_d, r_res_sh[WIDTH-1:1]};
                        r_borrow <= w_co;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

`default_nettype wire
